// File: rtl/mem_access_scheduler.sv
// Schedules MEM-stage data accesses against RAM1/RAM2/serial port: freezes the
// instruction port for RAM2 data accesses and stalls the pipeline meanwhile.
// Optional serial-port readiness wait enabled by `MEM_SCHED_UART_WAIT_EN.
module mem_access_scheduler #(
  parameter int unsigned FREEZE_CYCLES = 1,
  parameter int unsigned UART_TIMEOUT  = 1023
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  memRead,
  input  logic [1:0]  memWrite,
  input  logic [15:0] memAddress,
  input  logic        tbre,
  input  logic        tsre,
  input  logic        data_ready,
  output logic        freeze,
  output logic        stall,
  output logic        illegalAccess,
  output logic        uartTimeout
);

  localparam int unsigned CNT_W = 16;
  localparam logic [15:0] PORT_DATA_ADDR = 16'hBF00;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FREEZE    = 2'd1,
    RELEASE   = 2'd2,
    UART_WAIT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             rd_c, wr_c, both_c, conflict_c, wait_c;
  logic             stall_c, uart_set_c;

  // Access and region decode
  assign rd_c       = ((memRead == 2'b01) || (memRead == 2'b10)) && (memWrite == 2'b00);
  assign wr_c       = ((memWrite == 2'b01) || (memWrite == 2'b10)) && (memRead == 2'b00);
  assign both_c     = (memRead != 2'b00) && (memWrite != 2'b00);
  assign conflict_c = (rd_c || wr_c) && !memAddress[15];

`ifdef MEM_SCHED_UART_WAIT_EN
  assign wait_c = (memAddress == PORT_DATA_ADDR) &&
                  ((wr_c && !(tbre && tsre)) || (rd_c && !data_ready));
`else
  assign wait_c = 1'b0;
`endif

  // Next-state, counter and stall decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    illegal_d  = illegal_q || both_c;
    stall_c    = 1'b0;
    uart_set_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (conflict_c) begin
          stall_c = 1'b1;
          state_d = FREEZE;
          cnt_d   = CNT_W'(FREEZE_CYCLES - 1);
        end else if (wait_c) begin
          stall_c = 1'b1;
          state_d = UART_WAIT;
          cnt_d   = '0;
        end
      end
      FREEZE: begin
        stall_c = 1'b1;
        if (cnt_q == '0) begin
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      UART_WAIT: begin
        if (!wait_c) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(UART_TIMEOUT)) begin
          uart_set_c = 1'b1;
          state_d    = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef MEM_SCHED_UART_WAIT_EN
  logic uart_to_q, uart_to_d;

  assign uart_to_d = uart_to_q || uart_set_c;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      uart_to_q <= 1'b0;
    end else begin
      uart_to_q <= uart_to_d;
    end
  end

  assign uartTimeout = uart_to_q;
`else
  logic unused_c;
  assign unused_c    = ^{tbre, tsre, data_ready, memAddress[14:0], uart_set_c, PORT_DATA_ADDR};
  assign uartTimeout = 1'b0;
`endif

  // Reset gates stall so a held request cannot keep the pipeline frozen
  assign stall         = stall_c && !RST;
  assign freeze        = (state_q == FREEZE);
  assign illegalAccess = illegal_q;

endmodule

// File: tb/tb_mem_access_scheduler.sv
// Scoreboard bench for mem_access_scheduler (FREEZE_CYCLES=2, UART_TIMEOUT=8).
module tb_mem_access_scheduler;

  localparam int unsigned FC = 2;
  localparam int unsigned TO = 8;
`ifdef MEM_SCHED_UART_WAIT_EN
  localparam bit UART_EN = 1'b1;
`else
  localparam bit UART_EN = 1'b0;
`endif

  typedef struct packed {
    logic stall;
    logic freeze;
    logic ill;
    logic uto;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  memRead = 2'b00;
  logic [1:0]  memWrite = 2'b00;
  logic [15:0] memAddress = 16'h0000;
  logic        tbre = 1'b1;
  logic        tsre = 1'b1;
  logic        data_ready = 1'b1;
  logic        freeze, stall, illegalAccess, uartTimeout;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mem_access_scheduler #(.FREEZE_CYCLES(FC), .UART_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .memRead(memRead), .memWrite(memWrite),
    .memAddress(memAddress), .tbre(tbre), .tsre(tsre), .data_ready(data_ready),
    .freeze(freeze), .stall(stall), .illegalAccess(illegalAccess),
    .uartTimeout(uartTimeout)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_outputs(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, ".stall"},  stall,         e.stall);
      check_eq({tag, ".freeze"}, freeze,        e.freeze);
      check_eq({tag, ".ill"},    illegalAccess, e.ill);
      check_eq({tag, ".uto"},    uartTimeout,   e.uto);
    end
  endtask

  // One clock cycle: drive request, queue expectation, sample on negedge
  task automatic cycle(input string tag, input logic [1:0] rd, input logic [1:0] wr,
                       input logic [15:0] a, input logic tb, input logic ts, input logic dr,
                       input logic s, input logic f, input logic i, input logic u);
    exp_t e;
    memRead = rd; memWrite = wr; memAddress = a;
    tbre = tb; tsre = ts; data_ready = dr;
    e = '{stall: s, freeze: f, ill: i, uto: u};
    sb_q.push_back(e);
    @(negedge CLK);
    compare_outputs(tag);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic u_after;
    u_after = UART_EN;

    // Reset held three cycles, then idle
    for (int k = 0; k < 3; k++) cycle("reset", 2'b00, 2'b00, 16'h0000, 1, 1, 1, 0, 0, 0, 0);
    RST = 1'b0;
    for (int k = 0; k < 2; k++) cycle("idle", 2'b00, 2'b00, 16'h0000, 1, 1, 1, 0, 0, 0, 0);

    // RAM1 accesses never stall, including the port status address
    for (int k = 0; k < 3; k++) cycle("ram1_rd", 2'b01, 2'b00, 16'h8123, 1, 1, 1, 0, 0, 0, 0);
    cycle("ram1_wr", 2'b00, 2'b10, 16'hFFFF, 1, 1, 1, 0, 0, 0, 0);
    cycle("port_status", 2'b01, 2'b00, 16'hBF01, 0, 0, 0, 0, 0, 0, 0);

    // RAM2 write held while stalled, then a back-to-back conflict
    cycle("ram2_det",  2'b00, 2'b01, 16'h4000, 1, 1, 1, 1, 0, 0, 0);
    cycle("ram2_frz1", 2'b00, 2'b01, 16'h4000, 1, 1, 1, 1, 1, 0, 0);
    cycle("ram2_frz2", 2'b00, 2'b01, 16'h4000, 1, 1, 1, 1, 1, 0, 0);
    cycle("ram2_rel",  2'b00, 2'b01, 16'h4000, 1, 1, 1, 0, 0, 0, 0);
    cycle("b2b_det",   2'b10, 2'b00, 16'h0010, 1, 1, 1, 1, 0, 0, 0);
    cycle("b2b_frz1",  2'b10, 2'b00, 16'h0010, 1, 1, 1, 1, 1, 0, 0);
    cycle("b2b_frz2",  2'b10, 2'b00, 16'h0010, 1, 1, 1, 1, 1, 0, 0);
    cycle("b2b_rel",   2'b10, 2'b00, 16'h0010, 1, 1, 1, 0, 0, 0, 0);
    cycle("b2b_idle",  2'b00, 2'b00, 16'h0010, 1, 1, 1, 0, 0, 0, 0);
    cycle("addr_7fff", 2'b01, 2'b00, 16'h7FFF, 1, 1, 1, 1, 0, 0, 0);
    cycle("a7_frz1",   2'b01, 2'b00, 16'h7FFF, 1, 1, 1, 1, 1, 0, 0);
    cycle("a7_frz2",   2'b01, 2'b00, 16'h7FFF, 1, 1, 1, 1, 1, 0, 0);
    cycle("a7_rel",    2'b01, 2'b00, 16'h7FFF, 1, 1, 1, 0, 0, 0, 0);
    cycle("a7_idle",   2'b00, 2'b00, 16'h0000, 1, 1, 1, 0, 0, 0, 0);

    // Serial port data accesses
    if (UART_EN) begin
      for (int k = 0; k < 5; k++) cycle("uw_wr_wait", 2'b00, 2'b01, 16'hBF00, 0, 1, 1, 1, 0, 0, 0);
      cycle("uw_wr_ready", 2'b00, 2'b01, 16'hBF00, 1, 1, 1, 0, 0, 0, 0);
      cycle("uw_idle",     2'b00, 2'b00, 16'h0000, 1, 1, 1, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) cycle("uw_rd_wait", 2'b01, 2'b00, 16'hBF00, 1, 1, 0, 1, 0, 0, 0);
      cycle("uw_rd_ready", 2'b01, 2'b00, 16'hBF00, 1, 1, 1, 0, 0, 0, 0);
      cycle("uw_idle2",    2'b00, 2'b00, 16'h0000, 1, 1, 1, 0, 0, 0, 0);
      // Detection cycle plus TO counted wait cycles, then forced through
      for (int k = 0; k < TO + 1; k++) cycle("uto_wait", 2'b00, 2'b01, 16'hBF00, 0, 0, 1, 1, 0, 0, 0);
      cycle("uto_expire", 2'b00, 2'b01, 16'hBF00, 0, 0, 1, 0, 0, 0, 0);
      cycle("uto_sticky", 2'b00, 2'b00, 16'h0000, 1, 1, 1, 0, 0, 0, 1);
      cycle("uto_sticky2", 2'b01, 2'b00, 16'h8000, 1, 1, 1, 0, 0, 0, 1);
    end else begin
      for (int k = 0; k < 3; k++) cycle("uw_off_wr", 2'b00, 2'b01, 16'hBF00, 0, 0, 1, 0, 0, 0, 0);
      cycle("uw_off_rd", 2'b01, 2'b00, 16'hBF00, 1, 1, 0, 0, 0, 0, 0);
      cycle("uw_off_idle", 2'b00, 2'b00, 16'h0000, 1, 1, 1, 0, 0, 0, 0);
    end

    // Reset asserted during the first FREEZE cycle drops outputs asynchronously
    cycle("rm_det", 2'b00, 2'b01, 16'h0100, 1, 1, 1, 1, 0, 0, u_after);
    sb_q.push_back('{stall: 1'b1, freeze: 1'b1, ill: 1'b0, uto: u_after});
    @(negedge CLK);
    compare_outputs("rm_freeze");
    #1 RST = 1'b1;
    #1;
    sb_q.push_back('{stall: 1'b0, freeze: 1'b0, ill: 1'b0, uto: 1'b0});
    compare_outputs("rm_async");
    @(posedge CLK);
    #1 RST = 1'b0;
    cycle("rm_idle", 2'b00, 2'b00, 16'h0000, 1, 1, 1, 0, 0, 0, 0);
    cycle("rm_det2", 2'b00, 2'b01, 16'h0100, 1, 1, 1, 1, 0, 0, 0);
    cycle("rm_frz1", 2'b00, 2'b01, 16'h0100, 1, 1, 1, 1, 1, 0, 0);
    cycle("rm_frz2", 2'b00, 2'b01, 16'h0100, 1, 1, 1, 1, 1, 0, 0);
    cycle("rm_rel",  2'b00, 2'b01, 16'h0100, 1, 1, 1, 0, 0, 0, 0);

    // Illegal code: no stall even into RAM2, flag sticky until reset
    cycle("ill_det", 2'b01, 2'b10, 16'h4000, 1, 1, 1, 0, 0, 0, 0);
    cycle("ill_set", 2'b00, 2'b00, 16'h0000, 1, 1, 1, 0, 0, 1, 0);
    cycle("ill_hold", 2'b01, 2'b00, 16'h8000, 1, 1, 1, 0, 0, 1, 0);
    cycle("ill_rd11", 2'b11, 2'b00, 16'h0000, 1, 1, 1, 0, 0, 1, 0);
    RST = 1'b1;
    cycle("ill_clear", 2'b00, 2'b00, 16'h0000, 1, 1, 1, 0, 0, 0, 0);
    RST = 1'b0;
    cycle("final_idle", 2'b00, 2'b00, 16'h0000, 1, 1, 1, 0, 0, 0, 0);

    if (sb_q.size() != 0) check_eq("sb_leftover", 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
